writeback_lsu: RTL and testbench
================================

Name: writeback_lsu

Overview:
- Final pipeline stage, directly downstream of execute.
- Consumes execute's registered result, destination and memory-control outputs; drives the register-file write port.
- Performs all data-memory traffic over a valid/ready request channel and a separate read-response channel, so memory latency can vary.
- Stalls execute and fetch through stall_read while a memory access is outstanding.

Parameters:
- RESET, 32'h0000_0000, reset PC (kept for parameter parity across stages; unused internally).
- TIMEOUT, 16, maximum cycles in WAIT before a load is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- ex_valid  input  1  execute presents an instruction this cycle.
- ex_result  input  32  ALU result, or store data when ex_mem_write=1.
- ex_addr  input  32  data-memory byte address.
- ex_mem_write  input  1  store.
- ex_mem_to_reg  input  1  load.
- ex_alu_to_reg  input  1  ALU/lui/jal/jalr result is written to the register file.
- ex_dest_reg  input  5  destination register.
- ex_funct3  input  3  access size and sign (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
- stall_read  output  1  stage busy; upstream holds its state.
- dmem_req  output  1  memory request valid.
- dmem_we  output  1  request is a write.
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  output  32  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_ready  input  1  memory accepts the request.
- dmem_rvalid  input  1  read data valid.
- dmem_rdata  input  32  read data.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  write address.
- rf_wdata  output  32  write data.
- misalign  output  1  one-cycle pulse: misaligned access dropped.
- timeout_err  output  1  one-cycle pulse: load aborted.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0: stall_read, dmem_*, rf_*, misalign, timeout_err.
  - The timeout counter is cleared.
- States and stall:
  - States are IDLE, REQ and WAIT.
  - stall_read = (state != IDLE), decoded from registered state only.
- Accept: in IDLE with ex_valid=1, all ex_* inputs are captured in cycle N. Inputs are ignored in REQ and WAIT.
- ALU op (ex_alu_to_reg=1 and ex_mem_to_reg=0):
  - In cycle N+1, rf_we=1, rf_waddr=dest, rf_wdata=ex_result.
  - State stays IDLE, so back-to-back ALU ops proceed at 1 per cycle.
- Register x0: rf_we is never asserted for dest 0 in any path.
- Alignment:
  - Word access with addr[1:0]!=0, or halfword access with addr[0]=1, is misaligned.
  - A misaligned access gives misalign=1 in N+1, with no dmem_req and no rf_we; state stays IDLE.
- Memory op (aligned):
  - State is REQ from N+1.
  - dmem_req=1, and dmem_we/addr/wdata/be are held stable until the cycle in which dmem_ready=1.
- Store:
  - On the dmem_ready cycle M, the FSM returns to IDLE at M+1, where stall_read=0.
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
- Load:
  - On ready at cycle M, the FSM moves to WAIT at M+1. dmem_be is computed as for a store; dmem_wdata = 0.
  - dmem_rvalid is legal from M+1 onward. rvalid seen in REQ or IDLE is ignored.
  - On rvalid at cycle K, rf_we=1 at K+1 with the extracted data, and the FSM is in IDLE at K+1.
  - Extraction: byte select = rdata >> (8*addr[1:0]); halfword select = addr[1] ? rdata[31:16] : rdata[15:0].
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Timeout (TIMEOUT>0):
  - The counter clears when WAIT is entered and increments each WAIT cycle without rvalid.
  - When it reaches TIMEOUT, the FSM returns to IDLE with timeout_err=1 for one cycle and no rf_we.
  - rvalid arriving in the same cycle as the limit wins: the data is written and no error is flagged.
- Reset mid-operation: the FSM drops to IDLE the next edge and dmem_req falls. A late rvalid is then ignored.
- Unused ex_funct3 encodings in a memory op are treated as a word access.

Test Plan:
- ALU ops to x5 then x6 on consecutive cycles, values 0x1234, 0xABCD → rf_we=1 on the following two cycles with matching address and data; stall_read stays 0.
- SB to addr 0x1003, data 0x000000A5, dmem_ready delayed 3 cycles → dmem_be=4'b1000, wdata=0xA5A5A5A5, request held stable; stall_read high for 4 cycles, then 0.
- LH at 0x2002, rdata=0x8001_7FFF, rvalid 2 cycles after ready → rf_wdata=0xFFFF8001. Repeated as LHU → 0x00008001.
- LW at 0x3001 → misalign pulses once; no dmem_req and no rf_we.
- LW with TIMEOUT=4 and no rvalid → timeout_err pulses after 4 WAIT cycles and state returns to IDLE. A second run with rvalid on the 4th WAIT cycle → data written and no error.
- reset asserted while in WAIT, followed by rvalid → dmem_req=0 and rf_we=0; the next ALU op is written normally.

Source files
------------

// File: rtl/writeback_lsu.sv
// Writeback / load-store stage: retires ALU results to the register file and
// runs data-memory traffic over a valid/ready request plus read-response channel.
module writeback_lsu #(
  parameter logic [31:0] RESET   = 32'h0000_0000,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_addr,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_alu_to_reg,
  input  logic [4:0]  ex_dest_reg,
  input  logic [2:0]  ex_funct3,
  output logic        stall_read,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        misalign,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int            CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Access size: 0 byte, 1 halfword, 2 word (unused encodings fall to word).
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = 2'd0;
      3'b001, 3'b101: size_of = 2'd1;
      default:        size_of = 2'd2;
    endcase
  endfunction

  state_t        r_state;
  logic [1:0]    r_off;
  logic [2:0]    r_funct3;
  logic [4:0]    r_dest;
  logic [CW-1:0] r_cnt;

  logic [1:0]  w_size;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;
  logic        w_unused;

  assign w_unused   = ^RESET;
  assign stall_read = (r_state != S_IDLE);

  // Decode of the instruction presented by execute.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_size       = size_of(ex_funct3);
    w_misaligned = ((w_size == 2'd2) && (ex_addr[1:0] != 2'b00)) ||
                   ((w_size == 2'd1) && ex_addr[0]);
    w_be         = 4'b1111;
    w_wdata      = ex_result;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << ex_addr[1:0];
        w_wdata = {4{ex_result[7:0]}};
      end
      2'd1: begin
        w_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_result[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured access.
  always_comb begin
    w_shift   = dmem_rdata >> {r_off, 3'b000};
    w_half    = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ld_data = dmem_rdata;
    case (size_of(r_funct3))
      2'd0:    w_ld_data = {{24{~r_funct3[2] & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ld_data = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_off       <= 2'b00;
      r_funct3    <= 3'b000;
      r_dest      <= 5'd0;
      r_cnt       <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
      dmem_be     <= 4'b0000;
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'h0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rf_we       <= 1'b0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (ex_mem_write || ex_mem_to_reg) begin
              if (w_misaligned) begin
                misalign <= 1'b1;
              end else begin
                r_state    <= S_REQ;
                r_off      <= ex_addr[1:0];
                r_funct3   <= ex_funct3;
                r_dest     <= ex_dest_reg;
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_write;
                dmem_addr  <= {ex_addr[31:2], 2'b00};
                dmem_be    <= w_be;
                dmem_wdata <= ex_mem_write ? w_wdata : 32'h0;
              end
            end else if (ex_alu_to_reg && (ex_dest_reg != 5'd0)) begin
              rf_we    <= 1'b1;
              rf_waddr <= ex_dest_reg;
              rf_wdata <= ex_result;
            end
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            r_cnt    <= '0;
            r_state  <= dmem_we ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the limit cycle takes priority over the abort.
          if (dmem_rvalid) begin
            r_state  <= S_IDLE;
            rf_we    <= (r_dest != 5'd0);
            rf_waddr <= r_dest;
            rf_wdata <= w_ld_data;
          end else if ((TIMEOUT > 0) && (r_cnt == LIMIT)) begin
            r_state     <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_lsu.sv
// Directed bench for writeback_lsu: register-file writes are checked against a
// scoreboard queue; request channel, stall and error pulses are checked inline.
module tb_writeback_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = 32'h0;
  logic [31:0] ex_addr = 32'h0;
  logic        ex_mem_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        ex_alu_to_reg = 1'b0;
  logic [4:0]  ex_dest_reg = 5'd0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic        stall_read;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];

  writeback_lsu #(.RESET(32'h0), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_addr(ex_addr), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_to_reg(ex_alu_to_reg), .ex_dest_reg(ex_dest_reg), .ex_funct3(ex_funct3),
    .stall_read(stall_read), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign(misalign), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we) begin
      if (sb_q.size() == 0) begin
        check("rf_we_unexpected", 32'(rf_we), 32'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("rf_waddr", 32'(rf_waddr), 32'(e[36:32]));
        check("rf_wdata", rf_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_alu_to_reg = 1'b0;
  endtask

  task automatic drive(input logic we, input logic ld, input logic alu, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] res, input logic [4:0] dest);
    ex_valid = 1'b1; ex_mem_write = we; ex_mem_to_reg = ld; ex_alu_to_reg = alu;
    ex_funct3 = f3; ex_addr = addr; ex_result = res; ex_dest_reg = dest;
  endtask

  task automatic check_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    check({tag, "_stall"}, 32'(stall_read), 32'd1);
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_we"}, 32'(dmem_we), 32'(we));
    check({tag, "_addr"}, dmem_addr, addr);
    check({tag, "_be"}, 32'(dmem_be), 32'(be));
    check({tag, "_wdata"}, dmem_wdata, wdata);
  endtask

  task automatic do_alu(input logic [4:0] dest, input logic [31:0] val);
    drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, val, dest);
    if (dest != 5'd0) sb_q.push_back({dest, val});
    tick();
    clear_ex();
    check("alu_rf_we", 32'(rf_we), (dest != 5'd0) ? 32'd1 : 32'd0);
    check("alu_stall", 32'(stall_read), 32'd0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input int ready_delay, input logic [3:0] be, input logic [31:0] wdata);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    drive(1'b1, 1'b0, 1'b0, f3, addr, data, 5'd3);
    tick();
    clear_ex();
    for (int i = 0; i <= ready_delay; i++) begin
      check_req("st", 1'b1, waddr, be, wdata);
      if (i == ready_delay) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    check("st_done_stall", 32'(stall_read), 32'd0);
    check("st_done_req", 32'(dmem_req), 32'd0);
  endtask

  // One REQ cycle carries a stray rvalid (must be ignored), then ready, then
  // rvalid rv_delay cycles after the ready cycle.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] dest,
                         input logic [31:0] rdata, input int rv_delay, input logic [3:0] be,
                         input logic [31:0] exp);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    drive(1'b0, 1'b1, 1'b0, f3, addr, 32'hDEAD_BEEF, dest);
    if (dest != 5'd0) sb_q.push_back({dest, exp});
    tick();
    clear_ex();
    check_req("ld", 1'b0, waddr, be, 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = ~rdata;
    tick();
    dmem_rvalid = 1'b0;
    check_req("ld_hold", 1'b0, waddr, be, 32'h0);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check("ld_wait_stall", 32'(stall_read), 32'd1);
    check("ld_wait_req", 32'(dmem_req), 32'd0);
    repeat (rv_delay - 1) tick();
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0;
    check("ld_rf_we", 32'(rf_we), 32'd1);
    check("ld_done_stall", 32'(stall_read), 32'd0);
    check("ld_no_timeout", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_stall", 32'(stall_read), 32'd0);
    check("rst_dmem", {dmem_req, dmem_we, dmem_be, 26'd0}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_rf", {rf_we, rf_waddr, misalign, timeout_err, 24'd0}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // Back-to-back ALU writes, then a write to x0 that must be suppressed.
    do_alu(5'd5, 32'h0000_1234);
    do_alu(5'd6, 32'h0000_ABCD);
    do_alu(5'd0, 32'h0000_FFFF);
    tick();

    do_store(3'b000, 32'h0000_1003, 32'h0000_00A5, 3, 4'b1000, 32'hA5A5_A5A5);
    do_store(3'b001, 32'h0000_1006, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    do_store(3'b010, 32'h0000_1008, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);

    do_load(3'b001, 32'h0000_2002, 5'd8,  32'h8001_7FFF, 2, 4'b1100, 32'hFFFF_8001);
    do_load(3'b101, 32'h0000_2002, 5'd9,  32'h8001_7FFF, 2, 4'b1100, 32'h0000_8001);
    do_load(3'b000, 32'h0000_4001, 5'd10, 32'h1234_80AB, 1, 4'b0010, 32'hFFFF_FF80);
    do_load(3'b100, 32'h0000_4003, 5'd11, 32'hF000_0000, 1, 4'b1000, 32'h0000_00F0);

    // Misaligned word load and halfword store: one pulse, no request.
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd12);
    tick();
    clear_ex();
    check("mis_lw_pulse", 32'(misalign), 32'd1);
    check("mis_lw_req", 32'(dmem_req), 32'd0);
    check("mis_lw_stall", 32'(stall_read), 32'd0);
    tick();
    check("mis_lw_clear", 32'(misalign), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 5'd0);
    tick();
    clear_ex();
    check("mis_sh_pulse", 32'(misalign), 32'd1);
    check("mis_sh_req", 32'(dmem_req), 32'd0);
    tick();

    // Load with no response: abort after four WAIT cycles.
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd13);
    tick();
    clear_ex();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_stall", 32'(stall_read), 32'd1);
      check("to_wait_err", 32'(timeout_err), 32'd0);
      tick();
    end
    check("to_err_pulse", 32'(timeout_err), 32'd1);
    check("to_idle_stall", 32'(stall_read), 32'd0);
    tick();
    check("to_err_clear", 32'(timeout_err), 32'd0);

    // Response in the fourth WAIT cycle wins over the abort.
    do_load(3'b010, 32'h0000_5000, 5'd14, 32'h1357_9BDF, 4, 4'b1111, 32'h1357_9BDF);

    // Reset while REQ is pending drops the request.
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd15);
    tick();
    clear_ex();
    check("rreq_req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rreq_req_after", 32'(dmem_req), 32'd0);
    check("rreq_stall_after", 32'(stall_read), 32'd0);

    // Reset while in WAIT; the late response must not write.
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd16);
    tick();
    clear_ex();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check("rwait_stall_before", 32'(stall_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rwait_stall_after", 32'(stall_read), 32'd0);
    check("rwait_req_after", 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    tick();
    dmem_rvalid = 1'b0;
    check("rwait_late_rf_we", 32'(rf_we), 32'd0);
    do_alu(5'd7, 32'h0000_0055);

    tick();
    @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
